// File: rtl/reg_status_file.sv
// reg_status_file: architectural register file plus register-status (rename)
// table. Answers ROB commit lookups, takes commit writes, allocates rd tags at
// issue, serves rs1/rs2 operand reads with a commit bypass, and clears all
// busy state on a flush.
module reg_status_file #(
    parameter int REG_NUM = 32,
    parameter int REG_AW  = 5,
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              Clear_flag,
    // ROB commit interface
    input  logic [REG_AW-1:0] commit_rd,
    output logic              reg_busy_commit_rd,
    output logic [ROB_W-1:0]  reg_reorder_commit_rd,
    input  logic              ROB_to_Reg_needchange,
    input  logic [DATA_W-1:0] reg_reg_commit_rd_,
    input  logic [ROB_W-1:0]  commit_tag,
    // instruction queue: rd allocation
    input  logic              issue_en,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [ROB_W-1:0]  issue_tag,
    // instruction queue: operand lookup
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic [DATA_W-1:0] rs1_value,
    output logic [DATA_W-1:0] rs2_value,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic [ROB_W-1:0]  rs1_reorder,
    output logic [ROB_W-1:0]  rs2_reorder
);

    logic [DATA_W-1:0] reg_value   [REG_NUM];
    logic              reg_busy    [REG_NUM];
    logic [ROB_W-1:0]  reg_reorder [REG_NUM];

    // x0 is never written; every port also masks it on read
    logic commit_we;
    logic commit_release;
    logic issue_we;

    assign commit_we      = ROB_to_Reg_needchange && (commit_rd != '0);
    // release only when the committing entry is still the owner of rd
    assign commit_release = commit_we && reg_busy[commit_rd]
                            && (reg_reorder[commit_rd] == commit_tag);
    assign issue_we       = issue_en && (issue_rd != '0) && !Clear_flag;

    // register/status table update: commit write, busy release, issue allocation, flush
    // NOTE: the table is reset element by element because outputs must read 0
    // during reset and a stale busy bit after reset would deadlock issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                reg_value[i]   <= '0;
                reg_busy[i]    <= 1'b0;
                reg_reorder[i] <= '0;
            end
        end else if (rdy) begin
            // NOTE: non-blocking assignments here, so the later issue write
            // to the same rd overrides the release made just above it.
            if (commit_we) begin
                reg_value[commit_rd] <= reg_reg_commit_rd_;
            end
            if (Clear_flag) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    reg_busy[i]    <= 1'b0;
                    reg_reorder[i] <= '0;
                end
            end else begin
                if (commit_release) begin
                    reg_busy[commit_rd] <= 1'b0;
                end
                if (issue_we) begin
                    reg_busy[issue_rd]    <= 1'b1;
                    reg_reorder[issue_rd] <= issue_tag;
                end
            end
        end
    end

    // commit-port lookup: raw table value, no bypass, so the ROB sees the owner tag
    always_comb begin
        reg_busy_commit_rd    = 1'b0;
        reg_reorder_commit_rd = '0;
        if (commit_rd != '0) begin
            reg_busy_commit_rd    = reg_busy[commit_rd];
            reg_reorder_commit_rd = reg_reorder[commit_rd];
        end
    end

    // rs1 operand lookup with same-cycle commit bypass
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rs1_value   = '0;
        rs1_busy    = 1'b0;
        rs1_reorder = '0;
        if (rs1 != '0) begin
            if (ROB_to_Reg_needchange && (commit_rd == rs1) && reg_busy[rs1]
                && (reg_reorder[rs1] == commit_tag)) begin
                rs1_value = reg_reg_commit_rd_;
            end else begin
                rs1_value   = reg_value[rs1];
                rs1_busy    = reg_busy[rs1];
                rs1_reorder = reg_reorder[rs1];
            end
        end
    end

    // rs2 operand lookup with same-cycle commit bypass
    always_comb begin
        rs2_value   = '0;
        rs2_busy    = 1'b0;
        rs2_reorder = '0;
        if (rs2 != '0) begin
            if (ROB_to_Reg_needchange && (commit_rd == rs2) && reg_busy[rs2]
                && (reg_reorder[rs2] == commit_tag)) begin
                rs2_value = reg_reg_commit_rd_;
            end else begin
                rs2_value   = reg_value[rs2];
                rs2_busy    = reg_busy[rs2];
                rs2_reorder = reg_reorder[rs2];
            end
        end
    end

endmodule

// File: tb/tb_reg_status_file.sv
// tb_reg_status_file: directed bench for reg_status_file with hand-computed
// expectations checked by immediate assertions.
module tb_reg_status_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        Clear_flag;
    logic [4:0]  commit_rd;
    logic        reg_busy_commit_rd;
    logic [3:0]  reg_reorder_commit_rd;
    logic        ROB_to_Reg_needchange;
    logic [31:0] reg_reg_commit_rd_;
    logic [3:0]  commit_tag;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_tag;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [3:0]  rs1_reorder;
    logic [3:0]  rs2_reorder;

    int total = 0;
    int fails = 0;

    reg_status_file dut (
        .clk                   (clk),
        .rst                   (rst),
        .rdy                   (rdy),
        .Clear_flag            (Clear_flag),
        .commit_rd             (commit_rd),
        .reg_busy_commit_rd    (reg_busy_commit_rd),
        .reg_reorder_commit_rd (reg_reorder_commit_rd),
        .ROB_to_Reg_needchange (ROB_to_Reg_needchange),
        .reg_reg_commit_rd_    (reg_reg_commit_rd_),
        .commit_tag            (commit_tag),
        .issue_en              (issue_en),
        .issue_rd              (issue_rd),
        .issue_tag             (issue_tag),
        .rs1                   (rs1),
        .rs2                   (rs2),
        .rs1_value             (rs1_value),
        .rs2_value             (rs2_value),
        .rs1_busy              (rs1_busy),
        .rs2_busy              (rs2_busy),
        .rs1_reorder           (rs1_reorder),
        .rs2_reorder           (rs2_reorder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // return all strobes to idle
    task automatic idle();
        ROB_to_Reg_needchange = 1'b0;
        issue_en              = 1'b0;
        Clear_flag            = 1'b0;
    endtask

    // advance one rising edge, land 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [3:0] tag);
        issue_en = 1'b1; issue_rd = rd; issue_tag = tag;
        step();
        idle();
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1;
        Clear_flag = 1'b0; commit_rd = '0; ROB_to_Reg_needchange = 1'b0;
        reg_reg_commit_rd_ = '0; commit_tag = '0; issue_en = 1'b0;
        issue_rd = '0; issue_tag = '0; rs1 = 5'd5; rs2 = 5'd6;

        // reset state
        #12;
        check("reset_rs1_value", rs1_value, 32'h0);
        check("reset_rs1_busy", {31'b0, rs1_busy}, 32'h0);
        check("reset_rs2_reorder", {28'b0, rs2_reorder}, 32'h0);
        rst = 1'b0;
        step();

        // write x5 = 0x1234, then mark it busy, then async reset mid-cycle
        commit_rd = 5'd5; commit_tag = 4'd0; reg_reg_commit_rd_ = 32'h0000_1234;
        ROB_to_Reg_needchange = 1'b1;
        step();
        idle();
        do_issue(5'd5, 4'd7);
        check("pre_rst_value", rs1_value, 32'h0000_1234);
        check("pre_rst_busy", {31'b0, rs1_busy}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_value", rs1_value, 32'h0);
        check("async_rst_busy", {31'b0, rs1_busy}, 32'h0);
        check("async_rst_reorder", {28'b0, rs1_reorder}, 32'h0);
        #1 rst = 1'b0;
        step();

        // issue x5 tag 3
        do_issue(5'd5, 4'd3);
        commit_rd = 5'd5;
        #1;
        check("issue_rs1_busy", {31'b0, rs1_busy}, 32'h1);
        check("issue_rs1_reorder", {28'b0, rs1_reorder}, 32'h3);
        check("issue_commit_busy", {31'b0, reg_busy_commit_rd}, 32'h1);
        check("issue_commit_reorder", {28'b0, reg_reorder_commit_rd}, 32'h3);

        // commit x5 tag 3 with bypass
        commit_tag = 4'd3; reg_reg_commit_rd_ = 32'hDEAD_BEEF; ROB_to_Reg_needchange = 1'b1;
        #1;
        check("bypass_rs1_value", rs1_value, 32'hDEAD_BEEF);
        check("bypass_rs1_busy", {31'b0, rs1_busy}, 32'h0);
        check("bypass_rs1_reorder", {28'b0, rs1_reorder}, 32'h0);
        check("commit_port_unbypassed", {31'b0, reg_busy_commit_rd}, 32'h1);
        step();
        idle();
        check("commit_table_value", rs1_value, 32'hDEAD_BEEF);
        check("commit_table_busy", {31'b0, rs1_busy}, 32'h0);

        // stale commit on x7
        rs2 = 5'd7;
        do_issue(5'd7, 4'd2);
        do_issue(5'd7, 4'd9);
        commit_rd = 5'd7; commit_tag = 4'd2; reg_reg_commit_rd_ = 32'h11;
        ROB_to_Reg_needchange = 1'b1;
        #1;
        check("stale_no_bypass_value", rs2_value, 32'h0);
        check("stale_no_bypass_busy", {31'b0, rs2_busy}, 32'h1);
        check("stale_no_bypass_reorder", {28'b0, rs2_reorder}, 32'h9);
        step();
        idle();
        check("stale_value", rs2_value, 32'h11);
        check("stale_busy", {31'b0, rs2_busy}, 32'h1);
        check("stale_reorder", {28'b0, rs2_reorder}, 32'h9);

        // simultaneous commit and issue to x4
        rs1 = 5'd4;
        do_issue(5'd4, 4'd1);
        commit_rd = 5'd4; commit_tag = 4'd1; reg_reg_commit_rd_ = 32'h55;
        ROB_to_Reg_needchange = 1'b1;
        issue_en = 1'b1; issue_rd = 5'd4; issue_tag = 4'd6;
        #1;
        check("same_rd_bypass_value", rs1_value, 32'h55);
        check("same_rd_bypass_busy", {31'b0, rs1_busy}, 32'h0);
        step();
        idle();
        check("same_rd_value", rs1_value, 32'h55);
        check("same_rd_busy", {31'b0, rs1_busy}, 32'h1);
        check("same_rd_reorder", {28'b0, rs1_reorder}, 32'h6);

        // flush with a commit to x1 and an issue to x3
        do_issue(5'd1, 4'd4);
        do_issue(5'd2, 4'd5);
        Clear_flag = 1'b1;
        commit_rd = 5'd1; commit_tag = 4'd4; reg_reg_commit_rd_ = 32'h8000_0010;
        ROB_to_Reg_needchange = 1'b1;
        issue_en = 1'b1; issue_rd = 5'd3; issue_tag = 4'd7;
        step();
        idle();
        rs1 = 5'd1; rs2 = 5'd2;
        #1;
        check("flush_x1_value", rs1_value, 32'h8000_0010);
        check("flush_x1_busy", {31'b0, rs1_busy}, 32'h0);
        check("flush_x2_busy", {31'b0, rs2_busy}, 32'h0);
        check("flush_x2_reorder", {28'b0, rs2_reorder}, 32'h0);
        rs1 = 5'd3; rs2 = 5'd7; commit_rd = 5'd4;
        #1;
        check("flush_x3_busy", {31'b0, rs1_busy}, 32'h0);
        check("flush_x7_busy", {31'b0, rs2_busy}, 32'h0);
        check("flush_x4_commit_busy", {31'b0, reg_busy_commit_rd}, 32'h0);

        // x0: issue and commit are ignored
        rs1 = 5'd0;
        commit_rd = 5'd0; commit_tag = 4'd0; reg_reg_commit_rd_ = 32'hFF;
        ROB_to_Reg_needchange = 1'b1;
        issue_en = 1'b1; issue_rd = 5'd0; issue_tag = 4'd5;
        step();
        idle();
        check("x0_value", rs1_value, 32'h0);
        check("x0_busy", {31'b0, rs1_busy}, 32'h0);
        check("x0_reorder", {28'b0, rs1_reorder}, 32'h0);
        check("x0_commit_busy", {31'b0, reg_busy_commit_rd}, 32'h0);

        // stall: issue x8 and commit x5 with rdy low
        rdy = 1'b0;
        rs1 = 5'd8; rs2 = 5'd5;
        issue_en = 1'b1; issue_rd = 5'd8; issue_tag = 4'd2;
        commit_rd = 5'd5; commit_tag = 4'd0; reg_reg_commit_rd_ = 32'h0000_ABCD;
        ROB_to_Reg_needchange = 1'b1;
        step();
        idle();
        check("stall_x8_busy", {31'b0, rs1_busy}, 32'h0);
        check("stall_x5_value", rs2_value, 32'hDEAD_BEEF);
        rdy = 1'b1;
        step();
        check("unstall_x8_busy", {31'b0, rs1_busy}, 32'h0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/reg_status_file.md
Name: reg_status_file

Overview:
- Architectural register file plus register-status (rename) table for the Tomasulo core.
- Receiving end of the ROB commit interface:
  - answers the ROB's busy/reorder lookup for the committing rd;
  - takes the commit write (value, busy release).
- Also serves the instruction queue: rs1/rs2 operand lookups at issue, and rd busy/tag allocation at issue.
- Bulk-clears all busy state on a misprediction flush.

Parameters:
- REG_NUM, 32, number of architectural registers (x0 hardwired zero).
- REG_AW, 5, register index width.
- DATA_W, 32, register data width.
- ROB_W, 4, ROB tag width (16-entry ROB).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global ready; low = stall, all state held.
- Clear_flag  in  1  flush: release every busy bit.
- commit_rd  in  REG_AW  rd of the instruction at the ROB head.
- reg_busy_commit_rd  out  1  busy[commit_rd], raw table value.
- reg_reorder_commit_rd  out  ROB_W  reorder[commit_rd], raw table value.
- ROB_to_Reg_needchange  in  1  commit write strobe.
- reg_reg_commit_rd_  in  DATA_W  commit data.
- commit_tag  in  ROB_W  ROB index of the committing entry.
- issue_en  in  1  insqueue allocates rd.
- issue_rd  in  REG_AW  rd being allocated.
- issue_tag  in  ROB_W  ROB index given to rd.
- rs1, rs2  in  REG_AW  operand lookup indices.
- rs1_value, rs2_value  out  DATA_W  operand value.
- rs1_busy, rs2_busy  out  1  operand pending in ROB.
- rs1_reorder, rs2_reorder  out  ROB_W  producing ROB tag; valid when busy.

Behaviour:
- State per register: value[DATA_W], busy, reorder[ROB_W].
- Reset (async, rst high): all value = 0, busy = 0, reorder = 0. Outputs are combinational from state, so all read outputs read 0 during reset. Reset may assert mid-operation; it overrides everything immediately.
- rdy low (rst low): no state update; combinational outputs still track state.
- x0: value always reads 0; busy always reads 0; reorder always reads 0. Issue and commit to index 0 are ignored.
- Commit (rising edge, rdy=1, ROB_to_Reg_needchange=1, commit_rd != 0):
  - value[commit_rd] <= reg_reg_commit_rd_.
  - If busy[commit_rd] and reorder[commit_rd] == commit_tag: busy[commit_rd] <= 0.
  - Otherwise busy/reorder are unchanged, because a younger writer owns rd.
- Issue (rising edge, rdy=1, issue_en=1, issue_rd != 0, Clear_flag=0): busy[issue_rd] <= 1, reorder[issue_rd] <= issue_tag. Value is untouched.
- Same cycle, same rd, commit and issue: the commit value is written; busy = 1 and reorder = issue_tag (issue wins over the release).
- Clear_flag=1 (rdy=1):
  - every busy <= 0 and every reorder <= 0;
  - issue is ignored;
  - a commit in the same cycle still writes its value (the JALR/branch link write committed with the flush).
- Commit-port lookup: reg_busy_commit_rd and reg_reorder_commit_rd are combinational, zero-latency, and unbypassed, so the ROB can compute the release in the same cycle.
- Operand lookup (combinational, per port, with rsX != 0):
  - Bypass case: ROB_to_Reg_needchange=1, commit_rd == rsX, and the table entry is busy with reorder == commit_tag. Then value = reg_reg_commit_rd_, busy = 0, reorder = 0.
  - Otherwise the port returns the table value, busy, and reorder.
  - Issue in the same cycle never bypasses into rs1/rs2. The insqueue handles rd==rs ordering itself.
- Latency: writes are visible on the table outputs one cycle after the edge; the bypass gives zero-cycle visibility on the operand ports only.

Test Plan:
- Reset: pulse rst async mid-cycle after x5 has been written to 0x1234 -> rs1=5 reads value 0, busy 0 immediately, without waiting for a clock edge.
- Issue then commit, x5, tag 3:
  - issue rd=5, tag=3 -> next cycle rs1_busy=1, rs1_reorder=3, reg_busy_commit_rd=1 with commit_rd=5;
  - commit rd=5, tag=3, data 0xDEADBEEF -> same cycle rs1 bypass gives busy 0, value 0xDEADBEEF; next cycle the table matches.
- Stale commit: x7 issued with tag 2, then reissued with tag 9; commit rd=7, tag=2, data 0x11 -> value = 0x11, busy stays 1, reorder stays 9, no bypass on rs2=7.
- Simultaneous same-rd issue and commit: busy x4 with tag 1; in one cycle commit tag 1 data 0x55 and issue rd=4 tag 6 -> value 0x55, busy 1, reorder 6.
- Flush with commit: x1 busy tag 4, x2 busy tag 5; Clear_flag=1 with commit rd=1, tag 4, data 0x80000010, plus issue rd=3 -> all busy 0, x1 = 0x80000010, x3 not busy.
- x0 and stall:
  - issue and commit to rd=0 with data 0xFF -> rs1=0 reads 0, not busy;
  - with rdy=0, issue rd=8 -> x8 remains not busy after the edge.
